// File: rtl/btb_pkg.sv
// Shared types and helpers for the branch target buffer: counter limits,
// PC index/tag slicing and an entry struct for benches.
package btb_pkg;

    localparam int BTB_ADDR_W = 32;
    localparam int BTB_IDX_W  = 4;
    localparam int BTB_TAG_W  = 8;
    localparam int BTB_CNT_W  = 2;

    // Default-width counter values: new entries start weakly taken.
    localparam logic [BTB_CNT_W-1:0] BTB_CNT_INIT = 2'b10;
    localparam logic [BTB_CNT_W-1:0] BTB_CNT_MAX  = 2'b11;
    localparam logic [BTB_CNT_W-1:0] BTB_CNT_MIN  = 2'b00;

    typedef struct packed {
        logic                  valid;
        logic [BTB_TAG_W-1:0]  tag;
        logic [BTB_ADDR_W-3:0] target;
        logic [BTB_CNT_W-1:0]  cnt;
    } btb_entry_t;

    function automatic int unsigned btb_cnt_init(input int unsigned w);
        return 32'd1 << (w - 1);
    endfunction

    function automatic int unsigned btb_cnt_max(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

    function automatic int unsigned btb_idx(input logic [31:0] pc, input int unsigned idx_w);
        return (pc >> 2) & ((32'd1 << idx_w) - 32'd1);
    endfunction

    function automatic int unsigned btb_tag(input logic [31:0] pc, input int unsigned idx_w,
                                            input int unsigned tag_w);
        return (pc >> (idx_w + 2)) & ((32'd1 << tag_w) - 32'd1);
    endfunction

endpackage

// File: rtl/m_sat_counter.sv
// Combinational next value of a CNT_W-bit saturating up/down counter.
module m_sat_counter
    import btb_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic [CNT_W-1:0] cnt,
    input  logic             inc,
    output logic [CNT_W-1:0] nxt
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(btb_cnt_max(CNT_W));

    always_comb begin
        nxt = cnt;
        if (inc) begin
            if (cnt != CNT_MAX) nxt = cnt + CNT_W'(1);
        end else begin
            if (cnt != '0) nxt = cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/m_branch_target_buffer.sv
// Tagged direct-mapped BTB with saturating direction counters.
// Define BTB_BYPASS_EN to forward a same-edge update into the lookup result.
module m_branch_target_buffer
    import btb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int IDX_W  = 4,
    parameter int TAG_W  = 8,
    parameter int CNT_W  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ce,
    input  logic              lu_valid,
    input  logic [ADDR_W-1:0] lu_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              flush
);

    localparam int ENTRIES = 1 << IDX_W;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(btb_cnt_init(CNT_W));

    logic [ENTRIES-1:0] valid;
    logic [TAG_W-1:0]   tag_mem [ENTRIES];
    logic [ADDR_W-3:0]  tgt_mem [ENTRIES];
    logic [CNT_W-1:0]   cnt_mem [ENTRIES];

    logic [IDX_W-1:0] l_idx, u_idx;
    logic [TAG_W-1:0] l_tag, u_tag;
    logic             u_hit, u_wr, t_wr;
    logic [CNT_W-1:0] cnt_nxt, n_cnt;

    assign l_idx = lu_pc[IDX_W+1:2];
    assign l_tag = lu_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign u_idx = upd_pc[IDX_W+1:2];
    assign u_tag = upd_pc[IDX_W+TAG_W+1:IDX_W+2];

    logic unused_bits;
    assign unused_bits = ^{lu_pc[1:0], lu_pc[ADDR_W-1:IDX_W+TAG_W+2],
                           upd_pc[1:0], upd_pc[ADDR_W-1:IDX_W+TAG_W+2], upd_target[1:0]};

    assign u_hit = valid[u_idx] && (tag_mem[u_idx] == u_tag);

    m_sat_counter #(.CNT_W(CNT_W)) u_cnt (
        .cnt (cnt_mem[u_idx]),
        .inc (upd_taken),
        .nxt (cnt_nxt)
    );

    // Not-taken misses never allocate; flush drops any concurrent update.
    assign u_wr  = ce && upd_valid && !flush && (u_hit || upd_taken);
    assign t_wr  = u_wr && upd_taken;
    assign n_cnt = u_hit ? cnt_nxt : CNT_INIT;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (ce) begin
            if (flush)     valid        <= '0;
            else if (u_wr) valid[u_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (u_wr) begin
            tag_mem[u_idx] <= u_tag;
            cnt_mem[u_idx] <= n_cnt;
        end
        if (t_wr) tgt_mem[u_idx] <= upd_target[ADDR_W-1:2];
    end

    logic              r_valid;
    logic [TAG_W-1:0]  r_tag;
    logic [ADDR_W-3:0] r_tgt;
    logic [CNT_W-1:0]  r_cnt;
    logic              l_hit;

    always_comb begin
        r_valid = valid[l_idx];
        r_tag   = tag_mem[l_idx];
        r_tgt   = tgt_mem[l_idx];
        r_cnt   = cnt_mem[l_idx];
`ifdef BTB_BYPASS_EN
        if (u_wr && (u_idx == l_idx)) begin
            r_valid = 1'b1;
            r_tag   = u_tag;
            r_cnt   = n_cnt;
            if (upd_taken) r_tgt = upd_target[ADDR_W-1:2];
        end
`endif
    end

    assign l_hit = lu_valid && !flush && r_valid && (r_tag == l_tag);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_hit    <= 1'b0;
            pred_taken  <= 1'b0;
            pred_target <= '0;
        end else if (ce) begin
            pred_hit    <= l_hit;
            pred_taken  <= l_hit && r_cnt[CNT_W-1];
            pred_target <= l_hit ? {r_tgt, 2'b00} : '0;
        end
    end

endmodule

// File: tb/tb_m_branch_target_buffer.sv
// Randomised and directed bench for m_branch_target_buffer against a table model.
module tb_m_branch_target_buffer;
    import btb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, ce, lu_valid, upd_valid, upd_taken, flush;
    logic [31:0] lu_pc, upd_pc, upd_target;
    logic        pred_hit, pred_taken;
    logic [31:0] pred_target;

    m_branch_target_buffer #(.ADDR_W(32), .IDX_W(4), .TAG_W(8), .CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .ce(ce),
        .lu_valid(lu_valid), .lu_pc(lu_pc),
        .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .flush(flush)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    btb_entry_t  m [16];
    logic [33:0] exp_o = '0;
    logic [33:0] got;
    assign got = {pred_hit, pred_taken, pred_target};

    task automatic model_clear();
        for (int i = 0; i < 16; i++) m[i] = '0;
        exp_o = '0;
    endtask

    // Drive one cycle from a negedge, advance the model at the posedge, return at the next negedge.
    task automatic step(input bit c, input bit lv, input logic [31:0] lpc,
                        input bit uv, input logic [31:0] upc, input bit tk,
                        input logic [31:0] utg, input bit fl);
        logic [3:0] li, ui;
        logic [7:0] lt, ut;
        btb_entry_t view;
        ce = c; lu_valid = lv; lu_pc = lpc; upd_valid = uv; upd_pc = upc;
        upd_taken = tk; upd_target = utg; flush = fl;
        @(posedge clk);
        if (c) begin
            li = 4'(btb_idx(lpc, 4)); lt = 8'(btb_tag(lpc, 4, 8));
            ui = 4'(btb_idx(upc, 4)); ut = 8'(btb_tag(upc, 4, 8));
            view = m[li];
            if (fl) begin
                for (int i = 0; i < 16; i++) m[i].valid = 1'b0;
            end else if (uv) begin
                if (m[ui].valid && m[ui].tag == ut) begin
                    if (tk) begin
                        if (m[ui].cnt != 2'd3) m[ui].cnt = m[ui].cnt + 2'd1;
                        m[ui].target = utg[31:2];
                    end else if (m[ui].cnt != 2'd0) begin
                        m[ui].cnt = m[ui].cnt - 2'd1;
                    end
                end else if (tk) begin
                    m[ui] = '{valid: 1'b1, tag: ut, target: utg[31:2], cnt: 2'd2};
                end
            end
`ifdef BTB_BYPASS_EN
            view = m[li];
`endif
            if (lv && !fl && view.valid && view.tag == lt)
                exp_o = {1'b1, view.cnt >= 2'd2, view.target, 2'b00};
            else
                exp_o = '0;
        end
        @(negedge clk);
    endtask

    task automatic lookup(input logic [31:0] pc);
        step(1, 1, pc, 0, 32'h0, 0, 32'h0, 0);
    endtask

    task automatic update(input logic [31:0] pc, input bit tk, input logic [31:0] tgt);
        step(1, 0, 32'h0, 1, pc, tk, tgt, 0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ce = 0; lu_valid = 0; lu_pc = '0; upd_valid = 0; upd_pc = '0;
        upd_taken = 0; upd_target = '0; flush = 0;
        model_clear();
        #3;
        total++; if (got !== 34'h0) begin bad++; $display("FAIL reset_outputs got=%h exp=0", got); end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_lookup_miss();
        lookup(32'h40);
        total++; if (got !== 34'h0) begin bad++; $display("FAIL cold_miss got=%h exp=0", got); end
    endtask

    task automatic test_alloc();
        update(32'h40, 1, 32'h10);
        lookup(32'h40);
        total++; if (got !== {2'b11, 32'h10}) begin bad++; $display("FAIL alloc_hit got=%h exp=%h", got, {2'b11, 32'h10}); end
    endtask

    task automatic test_counter();
        update(32'h40, 0, 32'h0);
        update(32'h40, 0, 32'h0);
        lookup(32'h40);
        total++; if (got !== {2'b10, 32'h10}) begin bad++; $display("FAIL cnt_down got=%h exp=%h", got, {2'b10, 32'h10}); end
        update(32'h40, 0, 32'h0);
        update(32'h40, 1, 32'h10);
        lookup(32'h40);
        // one taken from a saturated-at-0 counter only reaches 1: still not taken
        total++; if (got !== {2'b10, 32'h10}) begin bad++; $display("FAIL cnt_floor got=%h exp=%h", got, {2'b10, 32'h10}); end
        for (int i = 0; i < 4; i++) update(32'h40, 1, 32'h10);
        lookup(32'h40);
        total++; if (got !== {2'b11, 32'h10}) begin bad++; $display("FAIL cnt_sat got=%h exp=%h", got, {2'b11, 32'h10}); end
        update(32'h40, 0, 32'h0);
        lookup(32'h40);
        total++; if (got !== {2'b11, 32'h10}) begin bad++; $display("FAIL cnt_ceiling got=%h exp=%h", got, {2'b11, 32'h10}); end
    endtask

    task automatic test_alias();
        lookup(32'h80);
        total++; if (got !== 34'h0) begin bad++; $display("FAIL alias_miss got=%h exp=0", got); end
        update(32'h80, 0, 32'h0);
        lookup(32'h40);
        total++; if (got[33] !== 1'b1) begin bad++; $display("FAIL alias_nt_keep got=%h exp_hit=1", got); end
        update(32'h80, 1, 32'h200);
        lookup(32'h40);
        total++; if (got !== 34'h0) begin bad++; $display("FAIL alias_evict got=%h exp=0", got); end
        lookup(32'h80);
        total++; if (got !== {2'b11, 32'h200}) begin bad++; $display("FAIL alias_new got=%h exp=%h", got, {2'b11, 32'h200}); end
    endtask

    task automatic test_flush_ce();
        update(32'h40, 1, 32'h10);
        step(1, 1, 32'h40, 1, 32'h44, 1, 32'h20, 1);
        total++; if (got !== 34'h0) begin bad++; $display("FAIL flush_edge_lookup got=%h exp=0", got); end
        lookup(32'h40);
        total++; if (got !== 34'h0) begin bad++; $display("FAIL flush_40 got=%h exp=0", got); end
        lookup(32'h44);
        total++; if (got !== 34'h0) begin bad++; $display("FAIL flush_44 got=%h exp=0", got); end
        update(32'h4C, 1, 32'h20);
        lookup(32'h4C);
        total++; if (got !== {2'b11, 32'h20}) begin bad++; $display("FAIL ce_setup got=%h exp=%h", got, {2'b11, 32'h20}); end
        step(0, 1, 32'h50, 1, 32'h50, 1, 32'h99, 1);
        step(0, 1, 32'h50, 1, 32'h4C, 0, 32'h0, 0);
        total++; if (got !== {2'b11, 32'h20}) begin bad++; $display("FAIL ce_hold got=%h exp=%h", got, {2'b11, 32'h20}); end
        lookup(32'h4C);
        total++; if (got !== {2'b11, 32'h20}) begin bad++; $display("FAIL ce_no_flush got=%h exp=%h", got, {2'b11, 32'h20}); end
        lookup(32'h50);
        total++; if (got !== 34'h0) begin bad++; $display("FAIL ce_no_update got=%h exp=0", got); end
    endtask

    task automatic test_same_edge();
        logic [33:0] want;
`ifdef BTB_BYPASS_EN
        want = {2'b11, 32'h300};
`else
        want = 34'h0;
`endif
        step(1, 1, 32'h48, 1, 32'h48, 1, 32'h300, 0);
        total++; if (got !== want) begin bad++; $display("FAIL same_edge got=%h exp=%h", got, want); end
        lookup(32'h48);
        total++; if (got !== {2'b11, 32'h300}) begin bad++; $display("FAIL same_edge_after got=%h exp=%h", got, {2'b11, 32'h300}); end
    endtask

    task automatic test_async_reset();
        lookup(32'h4C);
        total++; if (got !== {2'b11, 32'h20}) begin bad++; $display("FAIL pre_reset got=%h exp=%h", got, {2'b11, 32'h20}); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (got !== 34'h0) begin bad++; $display("FAIL async_reset got=%h exp=0", got); end
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        lookup(32'h4C);
        total++; if (got !== 34'h0) begin bad++; $display("FAIL reset_empty got=%h exp=0", got); end
    endtask

    task automatic test_random();
        logic [31:0] lpc, upc, utg;
        for (int n = 0; n < 400; n++) begin
            lpc = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
            upc = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
            utg = $urandom;
            step($urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0, lpc,
                 $urandom_range(0, 1) == 1, upc, $urandom_range(0, 1) == 1, utg,
                 $urandom_range(0, 15) == 0);
            total++; if (got !== exp_o) begin bad++; $display("FAIL random[%0d] got=%h exp=%h", n, got, exp_o); end
        end
    endtask

    initial begin
        test_reset();
        test_lookup_miss();
        test_alloc();
        test_counter();
        test_alias();
        test_flush_ce();
        test_same_edge();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
